dcache_commit_ctrl: RTL and testbench
=====================================

# dcache_commit_ctrl

Commit-side sequencer for the data cache's SRAM port 1 and the memory bus. It drains committed stores from the store buffer (write-through, no-allocate) and services committed load misses (4-beat line refill) and uncached loads. It drives the tag/data SRAM write port and returns load data to commit, while the dcache M1 pipeline keeps sole use of port 0.

## Interface
- WAY_NUM, 2: cache ways.
- DATA_DEPTH, 256: lines per way; index = paddr[11:4]; data word address = paddr[11:2].
- BEATS, 4: words per line (16 B).
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- sb_valid_i  in  1: store-buffer top entry valid.
- sb_addr_i / sb_data_i  in  32 / 32: top entry physical address / write data.
- sb_strb_i  in  4: top entry byte strobe.
- sb_uncached_i  in  1: top entry uncached.
- sb_pop_o  out  1: one-cycle pop of top entry (drives `fetch_sb`).
- ld_valid_i  in  1: committed load-miss request, level, held until ld_done_o.
- ld_paddr_i  in  32: load physical address.
- ld_uncached_i  in  1: uncached load.
- ld_done_o  out  1: one-cycle completion pulse.
- ld_rdata_o  out  32: raw word at ld_paddr_i[31:2], valid with ld_done_o.
- ram_addr_o  out  32: port-1 address (index/offset bits used).
- ram_way_o  out  WAY_NUM: one-hot way select for writes.
- ram_tag_we_o  out  1: tag write enable.
- ram_tag_o  out  $bits(cache_tag_t): tag write data.
- ram_strb_o  out  4: data byte write enables (0 = read).
- ram_wdata_o  out  32: data write data.
- ram_tag_rdata_i  in  WAY_NUM×cache_tag_t: port-1 tag read data, one cycle after address.
- bus_req_valid_o / bus_req_ready_i  out/in  1: request handshake.
- bus_req_write_o  out  1: 1 = write.
- bus_req_addr_o  out  32: request address (line-aligned for refill).
- bus_req_len_o  out  2: beats − 1 (3 for refill, 0 otherwise).
- bus_wdata_o / bus_wstrb_o  out  32 / 4: single-beat write data/strobe.
- bus_rvalid_i / bus_rdata_i / bus_rlast_i  in  1/32/1: read beats, always accepted.
- bus_bvalid_i  in  1: write response.

## Operation
- States: IDLE, ST_LOOK, ST_REQ, ST_RESP, LD_REQ, LD_DATA, LD_TAG.
- IDLE: sb_valid_i takes priority. A load starts only when sb_valid_i = 0, so the SB is empty before any refill and drained stores precede the load's memory read.
- Store path:
  - IDLE→ST_LOOK: drive sb_addr_i on ram_addr_o and latch the entry; ram_strb_o = 0.
  - ST_LOOK: if cached, compare ram_tag_rdata_i[w].v && tag == addr[31:12]. On hit, write ram_strb_o = sb_strb_i to the hit way in the same cycle. Uncached entries never write SRAM. Next state ST_REQ.
  - ST_REQ: bus write, len 0, until bus_req_ready_i, then ST_RESP.
  - ST_RESP: on bus_bvalid_i, pulse sb_pop_o and go to IDLE.
- Uncached load: LD_REQ (read, len 0, exact address) → LD_DATA. The first rvalid captures rdata and pulses ld_done_o, then IDLE.
- Cached load:
  - LD_REQ: read, len 3, addr & ~0xF; the victim way is latched from a 1-bit round-robin counter that toggles per refill.
  - LD_DATA: beat k (2-bit counter from 0) writes the victim way's data word, ram_addr_o = {line, k, 2'b00}, strb 4'hF. The beat with k == ld_paddr_i[3:2] is captured into ld_rdata_o.
  - On rlast, go to LD_TAG. There, write tag {v=1, tag=paddr[31:12]} to the victim way, pulse ld_done_o, then IDLE.
- Outputs are zero outside their states; ram_way_o and strb are never nonzero together with ram_tag_we_o except in LD_TAG (way only).

## Timing
- Reset: state IDLE, counters 0, victim 0. All outputs are 0, including ld_rdata_o.
- Cached store: ST_LOOK one cycle after IDLE; SRAM write in that cycle. sb_pop_o comes ≥ 3 cycles after start (1 cycle after bvalid).
- Refill latency: 1 + bus latency + 4 beats + 1 (LD_TAG). ld_done_o is the LD_TAG cycle.
- bus_req_valid_o holds with stable fields until bus_req_ready_i; no second request while one is outstanding.
- rvalid gaps are allowed and beat counter advances only on rvalid. An rlast without 4 beats still ends the refill.
- Reset mid-transaction returns to IDLE immediately; the bus side is assumed reset together.
- sb_valid_i and ld_valid_i asserting in the same cycle: the store wins and the load waits.

## Structure
- Shared package: cache_tag_t {v, tag[19:0]}, the ctrl_state_e enum, and the BEATS/index-slice constants shared with dcache.
- Single module; no sub-module needed.

## Test plan
- Cached store hit, way 1 tag 0x12345 at index 0x20, addr 0x12345204, strb 0011 → ST_LOOK writes way 1 word 0x81 strb 0011; bus write issued; sb_pop_o after bvalid.
- Store miss (tag mismatch) → no SRAM write; bus write only; one pop.
- Cached load 0x8000_0108, bus beats A0..A3 → four data writes at words 0x40..0x43, victim way 0; tag 0x80000 v=1 written; ld_rdata_o = A2; next refill uses way 1.
- Uncached load 0x1FE0_0004 → single len 0 read; ld_rdata_o = beat; no SRAM activity.
- Store and load valid simultaneously → store completes and pops before bus_req for the load.
- Reset asserted during LD_DATA beat 2 → all outputs 0 asynchronously; no tag write; IDLE after release.

Source files
------------

// File: rtl/dcache_commit_ctrl_pkg.sv
// Shared types and line geometry for the dcache commit-side sequencer.
// The tag layout and slice constants must match the dcache M1 pipeline.
package dcache_commit_ctrl_pkg;

  localparam int WAY_NUM  = 2;
  localparam int BEATS    = 4;
  localparam int LINE_LSB = 4;   // paddr[3:0] is the offset within a 16 B line
  localparam int TAG_LSB  = 12;  // paddr[31:12] is the tag, paddr[11:4] the index

  typedef struct packed {
    logic        v;
    logic [19:0] tag;
  } cache_tag_t;

  typedef enum logic [2:0] {
    IDLE,
    ST_LOOK,
    ST_REQ,
    ST_RESP,
    LD_REQ,
    LD_DATA,
    LD_TAG
  } ctrl_state_e;

  function automatic logic [WAY_NUM-1:0] way_onehot(input logic idx);
    return WAY_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/dcache_commit_ctrl_if.sv
// Memory-bus request/response bundle between the commit sequencer and the bus.
interface dcache_commit_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;
  logic        bvalid;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, wstrb,
    input  req_ready, rvalid, rdata, rlast, bvalid
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, wstrb,
    output req_ready, rvalid, rdata, rlast, bvalid
  );
endinterface

// File: rtl/dcache_commit_ctrl.sv
// Commit-side sequencer for dcache SRAM port 1: write-through store drain,
// 4-beat line refill for load misses, and single-beat uncached loads.
//
// state   | meaning
// IDLE    | waiting; store-buffer entry has priority over a load
// ST_LOOK | tag compare on port-1 read data; write the hit way
// ST_REQ  | single-beat bus write outstanding until accepted
// ST_RESP | waiting for write response, then pop the entry
// LD_REQ  | bus read outstanding (len 3 refill or len 0 uncached)
// LD_DATA | receiving read beats; refill beats written to victim way
// LD_TAG  | write victim tag and signal load completion
module dcache_commit_ctrl
  import dcache_commit_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sb_valid,
  input  logic [31:0]                   sb_addr,
  input  logic [31:0]                   sb_data,
  input  logic [3:0]                    sb_strb,
  input  logic                          sb_uncached,
  output logic                          sb_pop,
  input  logic                          ld_valid,
  input  logic [31:0]                   ld_paddr,
  input  logic                          ld_uncached,
  output logic                          ld_done,
  output logic [31:0]                   ld_rdata,
  output logic [31:0]                   ram_addr,
  output logic [WAY_NUM-1:0]            ram_way,
  output logic                          ram_tag_we,
  output cache_tag_t                    ram_tag,
  output logic [3:0]                    ram_strb,
  output logic [31:0]                   ram_wdata,
  input  cache_tag_t [WAY_NUM-1:0]      ram_tag_rdata,
  dcache_commit_ctrl_if.master          bus
);

  ctrl_state_e                  state;
  logic [31:0]                  st_addr;
  logic [31:0]                  st_data;
  logic [3:0]                   st_strb;
  logic                         st_unc;
  logic [$clog2(BEATS)-1:0]     beat;
  logic                         victim;
  logic                         rr;
  logic [31:0]                  rbuf;
  logic [WAY_NUM-1:0]           match;
  logic [WAY_NUM-1:0]           hit_way;

  // Lowest matching way wins if the tag array ever holds a duplicate.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAY_NUM; w++)
      match[w] = ram_tag_rdata[w].v && (ram_tag_rdata[w].tag == st_addr[31:TAG_LSB]);
    hit_way = match & (~match + WAY_NUM'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      st_addr       <= '0;
      st_data       <= '0;
      st_strb       <= '0;
      st_unc        <= 1'b0;
      beat          <= '0;
      victim        <= 1'b0;
      rr            <= 1'b0;
      rbuf          <= '0;
      sb_pop        <= 1'b0;
      ld_done       <= 1'b0;
      ld_rdata      <= '0;
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_addr  <= '0;
      bus.req_len   <= '0;
      bus.wdata     <= '0;
      bus.wstrb     <= '0;
    end else begin
      sb_pop   <= 1'b0;
      ld_done  <= 1'b0;
      ld_rdata <= '0;
      case (state)
        IDLE: begin
          // Requesters still show the finished entry during a pop/done pulse.
          if (!sb_pop && !ld_done) begin
            if (sb_valid) begin
              st_addr <= sb_addr;
              st_data <= sb_data;
              st_strb <= sb_strb;
              st_unc  <= sb_uncached;
              state   <= ST_LOOK;
            end else if (ld_valid) begin
              beat          <= '0;
              bus.req_valid <= 1'b1;
              bus.req_write <= 1'b0;
              if (ld_uncached) begin
                bus.req_addr <= ld_paddr;
                bus.req_len  <= 2'd0;
              end else begin
                bus.req_addr <= {ld_paddr[31:LINE_LSB], {LINE_LSB{1'b0}}};
                bus.req_len  <= 2'(BEATS - 1);
                victim       <= rr;
                rr           <= ~rr;
              end
              state <= LD_REQ;
            end
          end
        end
        ST_LOOK: begin
          bus.req_valid <= 1'b1;
          bus.req_write <= 1'b1;
          bus.req_addr  <= st_addr;
          bus.req_len   <= 2'd0;
          bus.wdata     <= st_data;
          bus.wstrb     <= st_strb;
          state         <= ST_REQ;
        end
        ST_REQ: begin
          if (bus.req_ready) begin
            bus.req_valid <= 1'b0;
            bus.req_write <= 1'b0;
            bus.req_addr  <= '0;
            bus.wdata     <= '0;
            bus.wstrb     <= '0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.bvalid) begin
            sb_pop <= 1'b1;
            state  <= IDLE;
          end
        end
        LD_REQ: begin
          if (bus.req_ready) begin
            bus.req_valid <= 1'b0;
            bus.req_addr  <= '0;
            bus.req_len   <= '0;
            state         <= LD_DATA;
          end
        end
        LD_DATA: begin
          if (bus.rvalid) begin
            if (ld_uncached) begin
              ld_done  <= 1'b1;
              ld_rdata <= bus.rdata;
              state    <= IDLE;
            end else begin
              beat <= beat + 1'b1;
              if (beat == ld_paddr[LINE_LSB-1:2])
                rbuf <= bus.rdata;
              // A short burst still ends the refill; the tag is written regardless.
              if (bus.rlast) begin
                ld_done  <= 1'b1;
                ld_rdata <= (beat == ld_paddr[LINE_LSB-1:2]) ? bus.rdata : rbuf;
                state    <= LD_TAG;
              end
            end
          end
        end
        LD_TAG: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port-1 drive is decoded from state: the store address must be on the
  // port in IDLE so the tag read lands in ST_LOOK, where the write follows.
  always_comb begin
    ram_addr   = '0;
    ram_way    = '0;
    ram_tag_we = 1'b0;
    ram_tag    = '0;
    ram_strb   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        if (sb_valid && !sb_pop && !ld_done)
          ram_addr = sb_addr;
      end
      ST_LOOK: begin
        ram_addr = st_addr;
        if (!st_unc && (hit_way != '0)) begin
          ram_way   = hit_way;
          ram_strb  = st_strb;
          ram_wdata = st_data;
        end
      end
      LD_DATA: begin
        if (!ld_uncached) begin
          ram_addr = {ld_paddr[31:LINE_LSB], beat, 2'b00};
          if (bus.rvalid) begin
            ram_way   = way_onehot(victim);
            ram_strb  = 4'hF;
            ram_wdata = bus.rdata;
          end
        end
      end
      LD_TAG: begin
        ram_addr   = {ld_paddr[31:LINE_LSB], {LINE_LSB{1'b0}}};
        ram_way    = way_onehot(victim);
        ram_tag_we = 1'b1;
        ram_tag.v   = 1'b1;
        ram_tag.tag = ld_paddr[31:TAG_LSB];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_commit_ctrl.sv
// Scoreboard bench for dcache_commit_ctrl: directed stores/loads push expected
// SRAM writes, bus requests, pops and load data; a monitor pops and compares.
module tb_dcache_commit_ctrl;
  import dcache_commit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     sb_valid, sb_uncached, sb_pop;
  logic [31:0]              sb_addr, sb_data;
  logic [3:0]               sb_strb;
  logic                     ld_valid, ld_uncached, ld_done;
  logic [31:0]              ld_paddr, ld_rdata;
  logic [31:0]              ram_addr, ram_wdata;
  logic [WAY_NUM-1:0]       ram_way;
  logic                     ram_tag_we;
  cache_tag_t               ram_tag;
  logic [3:0]               ram_strb;
  cache_tag_t [WAY_NUM-1:0] tags;

  dcache_commit_ctrl_if bus();

  dcache_commit_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_data(sb_data), .sb_strb(sb_strb),
    .sb_uncached(sb_uncached), .sb_pop(sb_pop),
    .ld_valid(ld_valid), .ld_paddr(ld_paddr), .ld_uncached(ld_uncached),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_way(ram_way), .ram_tag_we(ram_tag_we), .ram_tag(ram_tag),
    .ram_strb(ram_strb), .ram_wdata(ram_wdata), .ram_tag_rdata(tags),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]  way;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        tag_we;
    cache_tag_t  tag;
  } ram_ev_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  pops;
  } req_ev_t;

  ram_ev_t     exp_ram[$];
  req_ev_t     exp_req[$];
  logic [31:0] exp_ld[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_pops = 0;
  int          pops_seen = 0;
  logic [31:0] rd_words [4];
  bit          gap = 1'b0;
  int          stall_at = -1;
  bit          stalled = 1'b0;

  logic [255:0] all_outs;
  assign all_outs = 256'({sb_pop, ld_done, ld_rdata, ram_addr, ram_way, ram_tag_we, ram_tag,
                          ram_strb, ram_wdata, bus.req_valid, bus.req_write, bus.req_addr,
                          bus.req_len, bus.wdata, bus.wstrb});

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard queues.
  always @(negedge clk) begin
    ram_ev_t a;
    req_ev_t r;
    if (rst_n) begin
      if (ram_strb != 4'h0 || ram_tag_we) begin
        a.way = ram_way; a.addr = ram_addr; a.strb = ram_strb;
        a.wdata = ram_wdata; a.tag_we = ram_tag_we; a.tag = ram_tag;
        if (exp_ram.size() == 0) begin
          checks++; failures++;
          $display("FAIL ram_write unexpected actual=%0h", a);
        end else check("ram_write", 256'(a), 256'(exp_ram.pop_front()));
      end
      if (bus.req_valid && bus.req_ready) begin
        r.write = bus.req_write; r.addr = bus.req_addr; r.len = bus.req_len;
        r.wdata = bus.wdata; r.wstrb = bus.wstrb; r.pops = 8'(pops_seen);
        if (exp_req.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_req unexpected actual=%0h", r);
        end else check("bus_req", 256'(r), 256'(exp_req.pop_front()));
      end
      if (sb_pop) begin
        check("sb_pop_expected", 256'(pops_seen < exp_pops), 256'(1));
        pops_seen++;
      end
      if (ld_done) begin
        if (exp_ld.size() == 0) begin
          checks++; failures++;
          $display("FAIL ld_done unexpected actual=%0h", ld_rdata);
        end else check("ld_rdata", 256'(ld_rdata), 256'(exp_ld.pop_front()));
      end
    end
  end

  // Bus slave: one wait cycle before ready, write response or read beats after.
  initial begin : slave
    bit wr;
    int len;
    bus.req_ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rlast = 1'b0; bus.bvalid = 1'b0;
    forever begin
      tick();
      if (rst_n && bus.req_valid) begin
        wr  = bus.req_write;
        len = int'(bus.req_len);
        tick();
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        if (wr) begin
          tick();
          bus.bvalid = 1'b1;
          tick();
          bus.bvalid = 1'b0;
        end else begin
          for (int k = 0; k <= len; k++) begin
            if (k == stall_at) begin
              stalled = 1'b1;
              break;
            end
            if (gap && k == 2) begin
              bus.rvalid = 1'b0;
              tick();
            end
            bus.rvalid = 1'b1;
            bus.rdata  = rd_words[k];
            bus.rlast  = (k == len);
            tick();
          end
          bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0;
        end
      end
    end
  end

  task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic unc, input logic [1:0] hit);
    ram_ev_t e;
    req_ev_t r;
    if (hit != 2'b00) begin
      e.way = hit; e.addr = a; e.strb = s; e.wdata = d; e.tag_we = 1'b0; e.tag = '0;
      exp_ram.push_back(e);
    end
    r.write = 1'b1; r.addr = a; r.len = 2'd0; r.wdata = d; r.wstrb = s; r.pops = 8'(exp_pops);
    exp_req.push_back(r);
    exp_pops++;
    sb_addr = a; sb_data = d; sb_strb = s; sb_uncached = unc; sb_valid = 1'b1;
  endtask

  task automatic issue_load(input logic [31:0] a, input logic unc, input logic [1:0] way,
                            input int nbeats, input bit gp);
    ram_ev_t     e;
    req_ev_t     r;
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    r.write = 1'b0; r.addr = unc ? a : line; r.len = unc ? 2'd0 : 2'd3;
    r.wdata = '0; r.wstrb = '0; r.pops = 8'(exp_pops);
    exp_req.push_back(r);
    if (!unc) begin
      for (int k = 0; k < nbeats; k++) begin
        e.way = way; e.addr = line + 32'(4 * k); e.strb = 4'hF; e.wdata = rd_words[k];
        e.tag_we = 1'b0; e.tag = '0;
        exp_ram.push_back(e);
      end
      if (nbeats == 4) begin
        e.way = way; e.addr = line; e.strb = 4'h0; e.wdata = '0; e.tag_we = 1'b1;
        e.tag.v = 1'b1; e.tag.tag = a[31:12];
        exp_ram.push_back(e);
      end
    end
    if (nbeats == 4) exp_ld.push_back(unc ? rd_words[0] : rd_words[a[3:2]]);
    gap = gp;
    ld_paddr = a; ld_uncached = unc; ld_valid = 1'b1;
  endtask

  task automatic run_until_idle();
    int n;
    bit drop_sb, drop_ld;
    n = 0; drop_sb = 1'b0; drop_ld = 1'b0;
    while ((sb_valid || ld_valid) && n < 400) begin
      @(negedge clk);
      if (sb_pop)  drop_sb = 1'b1;
      if (ld_done) drop_ld = 1'b1;
      tick();
      if (drop_sb) sb_valid = 1'b0;
      if (drop_ld) ld_valid = 1'b0;
      drop_sb = 1'b0; drop_ld = 1'b0;
      n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL transaction_timeout actual=%0d required<400", n);
      sb_valid = 1'b0; ld_valid = 1'b0;
    end
    repeat (3) tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    sb_valid = 1'b0; sb_addr = '0; sb_data = '0; sb_strb = '0; sb_uncached = 1'b0;
    ld_valid = 1'b0; ld_paddr = '0; ld_uncached = 1'b0;
    tags = '0;
    foreach (rd_words[i]) rd_words[i] = '0;
    repeat (3) tick();
    check("reset_outputs", all_outs, '0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_outputs", all_outs, '0);

    // Cached store hit on way 1
    tags[1].v = 1'b1; tags[1].tag = 20'h12345;
    tags[0].v = 1'b1; tags[0].tag = 20'h00001;
    issue_store(32'h1234_5204, 32'hDEAD_BEEF, 4'b0011, 1'b0, 2'b10);
    @(negedge clk);
    check("store_idle_addr", 256'(ram_addr), 256'(32'h1234_5204));
    @(negedge clk);
    check("store_look_strb", 256'(ram_strb), 256'(4'b0011));
    run_until_idle();

    // Store miss: way 1 tag matches but is invalid
    tags[0].v = 1'b1; tags[0].tag = 20'h00AAA;
    tags[1].v = 1'b0; tags[1].tag = 20'h12345;
    issue_store(32'h1234_5208, 32'h1122_3344, 4'b1111, 1'b0, 2'b00);
    run_until_idle();

    // Uncached store with a matching valid tag never writes SRAM
    tags[1].v = 1'b1;
    issue_store(32'h1234_5204, 32'h5566_7788, 4'b1100, 1'b1, 2'b00);
    run_until_idle();

    // Cached refill, victim way 0, gap before beat 2, critical word is beat 2
    rd_words[0] = 32'h1111_00A0; rd_words[1] = 32'h2222_00A1;
    rd_words[2] = 32'h3333_00A2; rd_words[3] = 32'h4444_00A3;
    issue_load(32'h8000_0108, 1'b0, 2'b01, 4, 1'b1);
    run_until_idle();

    // Second refill uses way 1; requested word arrives on the last beat
    rd_words[0] = 32'h5555_00B0; rd_words[1] = 32'h6666_00B1;
    rd_words[2] = 32'h7777_00B2; rd_words[3] = 32'h8888_00B3;
    issue_load(32'h8000_013C, 1'b0, 2'b10, 4, 1'b0);
    run_until_idle();

    // Uncached load
    rd_words[0] = 32'hCAFE_F00D;
    issue_load(32'h1FE0_0004, 1'b1, 2'b00, 4, 1'b0);
    run_until_idle();

    // Store and load together: store drains and pops before the load request
    tags[0].v = 1'b1; tags[0].tag = 20'h00AAA;
    tags[1].v = 1'b0;
    rd_words[0] = 32'h600D_D00D;
    issue_store(32'h0000_0044, 32'h0BAD_F00D, 4'hF, 1'b0, 2'b00);
    issue_load(32'h1FE0_0010, 1'b1, 2'b00, 4, 1'b0);
    run_until_idle();

    // Reset in the middle of a refill, before beat 2
    rd_words[0] = 32'h9999_00C0; rd_words[1] = 32'hAAAA_00C1;
    rd_words[2] = 32'hBBBB_00C2; rd_words[3] = 32'hCCCC_00C3;
    stall_at = 2;
    issue_load(32'h8000_0200, 1'b0, 2'b01, 2, 1'b0);
    n = 0;
    while (!stalled && n < 200) begin
      tick();
      n++;
    end
    check("stall_reached", 256'(stalled), 256'(1));
    @(negedge clk);
    check("refill_addr_beat2", 256'(ram_addr), 256'(32'h8000_0208));
    #2;
    rst_n = 1'b0;
    ld_valid = 1'b0;
    #1;
    check("reset_mid_refill", all_outs, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    stall_at = -1;
    stalled = 1'b0;
    repeat (2) tick();
    check("idle_after_reset", all_outs, '0);

    // Round-robin restarts at way 0 after reset
    rd_words[0] = 32'hD0D0_0001; rd_words[1] = 32'hD0D0_0002;
    rd_words[2] = 32'hD0D0_0003; rd_words[3] = 32'hD0D0_0004;
    issue_load(32'h8000_0300, 1'b0, 2'b01, 4, 1'b0);
    run_until_idle();

    repeat (5) tick();
    check("ram_queue_empty", 256'(exp_ram.size()), '0);
    check("req_queue_empty", 256'(exp_req.size()), '0);
    check("ld_queue_empty", 256'(exp_ld.size()), '0);
    check("pop_count", 256'(pops_seen), 256'(exp_pops));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
